// File: rtl/oversampling_rx_pkg.sv
// oversampling_rx_pkg
// Shared types and helpers for the oversampling frame receiver:
//   rx_state_e  - receiver FSM state encoding
//   MIN_OSR     - smallest supported samples-per-bit
//   cnt_width() - width of a counter that must hold 0..max_words
package oversampling_rx_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    RECEIVE = 3'd2,
    STOP    = 3'd3,
    FLUSH   = 3'd4
  } rx_state_e;

  localparam int MIN_OSR = 4;

  function automatic int cnt_width(input int max_words);
    return $clog2(max_words + 1);
  endfunction

endpackage

// File: rtl/oversampling_phase_detect.sv
// oversampling_phase_detect
// Finds the earliest low sample in the newest sample word and captures the
// mid-bit sampling position p = i + OSR/2 into the history window.
// Ports:
//   clk, sync_reset  clock and synchronous active-high reset
//   load_i           capture p from the current sample word
//   s_d1_i [OSR]     newest registered sample word (bit 0 earliest)
//   any_low_o        some sample in s_d1_i is low
//   p_o [PW]         captured sampling index into {s_d1, s_d2}
module oversampling_phase_detect #(
  parameter int OSR = 4,
  parameter int PW  = $clog2(2 * OSR)
) (
  input  logic           clk,
  input  logic           sync_reset,
  input  logic           load_i,
  input  logic [OSR-1:0] s_d1_i,
  output logic           any_low_o,
  output logic [PW-1:0]  p_o
);

  localparam int IW = $clog2(OSR);

  logic [IW-1:0] start_idx;
  logic [PW-1:0] p_d, p_q;

  // Scan from the latest sample down so the earliest low one wins.
  always_comb begin
    any_low_o = 1'b0;
    start_idx = '0;
    for (int k = OSR - 1; k >= 0; k--) begin
      if (!s_d1_i[k]) begin
        any_low_o = 1'b1;
        start_idx = IW'(k);
      end
    end
  end

  always_comb begin
    p_d = p_q;
    if (load_i) begin
      p_d = PW'(start_idx) + PW'(OSR / 2);
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      p_q <= '0;
    end else begin
      p_q <= p_d;
    end
  end

  assign p_o = p_q;

endmodule

// File: rtl/oversampling_rx_framer.sv
// oversampling_rx_framer
// Oversampling serial frame receiver: start bit, WORD_WIDTH data bits LSB
// first, then a continuation bit (0 = another word, 1 = end of frame).
// One bit period per clk, OSR samples per clk.
// Build option: OVERSAMPLING_RX_MAJORITY_EN selects a 3-sample majority vote
// around the sampling point instead of a single sample.
// Ports:
//   clk, sync_reset      clock and synchronous active-high reset
//   enable               arms start detection (looked at only in IDLE)
//   samples [OSR]        oversampled line, bit 0 earliest
//   word_out [WORD_WIDTH] last received word
//   word_write           one-cycle strobe, word_out updated
//   frame_complete       strobe with the last word of a frame
//   frame_words          word count, valid with frame_complete/frame_error
//   frame_error          strobe, frame reached MAX_WORDS without ending
//
// state   | meaning
// IDLE    | waiting for a low sample with enable set
// START   | checking the mid-start-bit sample (1 = false start)
// RECEIVE | shifting in data bits
// STOP    | sampling the continuation bit, emitting the word
// FLUSH   | after overflow, waiting for IDLE_BITS consecutive 1 bits
module oversampling_rx_framer
  import oversampling_rx_pkg::*;
#(
  parameter int WORD_WIDTH = 8,
  parameter int OSR        = 4,
  parameter int MAX_WORDS  = 16,
  parameter int IDLE_BITS  = 4
) (
  input  logic                            clk,
  input  logic                            sync_reset,
  input  logic                            enable,
  input  logic [OSR-1:0]                  samples,
  output logic [WORD_WIDTH-1:0]           word_out,
  output logic                            word_write,
  output logic                            frame_complete,
  output logic [cnt_width(MAX_WORDS)-1:0] frame_words,
  output logic                            frame_error
);

  localparam int PW = $clog2(2 * OSR);
  localparam int BW = $clog2(WORD_WIDTH);
  localparam int CW = cnt_width(MAX_WORDS);
  localparam int FW = $clog2(IDLE_BITS + 1);

  if (OSR < MIN_OSR || OSR > 16) begin : g_osr_range
    $error("oversampling_rx_framer: OSR must be in 4..16");
  end

  rx_state_e state_q, state_d;

  logic [OSR-1:0]        s_d1_q, s_d2_q;
  logic [2*OSR-1:0]      h;
  logic [PW-1:0]         p_q;
  logic                  any_low;
  logic                  p_load;
  logic                  bit_b;

  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]         word_cnt_q, word_cnt_d, words_inc;
  logic [FW-1:0]         idle_cnt_q, idle_cnt_d, idle_inc;
  logic [WORD_WIDTH-1:0] shift_q, shift_d;

  logic [WORD_WIDTH-1:0] word_out_q, word_out_d;
  logic                  word_write_q, word_write_d;
  logic                  frame_complete_q, frame_complete_d;
  logic                  frame_error_q, frame_error_d;
  logic [CW-1:0]         frame_words_q, frame_words_d;

  assign h = {s_d1_q, s_d2_q};

  oversampling_phase_detect #(
    .OSR (OSR),
    .PW  (PW)
  ) u_phase (
    .clk        (clk),
    .sync_reset (sync_reset),
    .load_i     (p_load),
    .s_d1_i     (s_d1_q),
    .any_low_o  (any_low),
    .p_o        (p_q)
  );

`ifdef OVERSAMPLING_RX_MAJORITY_EN
  logic [PW-1:0] p_lo, p_hi;
  logic          v_lo, v_mid, v_hi;
  assign p_lo  = p_q - PW'(1);
  assign p_hi  = p_q + PW'(1);
  assign v_lo  = h[p_lo];
  assign v_mid = h[p_q];
  assign v_hi  = h[p_hi];
  assign bit_b = (v_lo & v_mid) | (v_lo & v_hi) | (v_mid & v_hi);
`else
  assign bit_b = h[p_q];
`endif

  assign words_inc = word_cnt_q + CW'(1);
  assign idle_inc  = idle_cnt_q + FW'(1);

  always_comb begin
    state_d          = state_q;
    bit_cnt_d        = bit_cnt_q;
    word_cnt_d       = word_cnt_q;
    idle_cnt_d       = idle_cnt_q;
    shift_d          = shift_q;
    word_out_d       = word_out_q;
    word_write_d     = 1'b0;
    frame_complete_d = 1'b0;
    frame_error_d    = 1'b0;
    frame_words_d    = frame_words_q;
    p_load           = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable && any_low) begin
          p_load  = 1'b1;
          state_d = START;
        end
      end

      START: begin
        if (!bit_b) begin
          state_d    = RECEIVE;
          bit_cnt_d  = BW'(WORD_WIDTH - 1);
          word_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end

      RECEIVE: begin
        shift_d = {bit_b, shift_q[WORD_WIDTH-1:1]};
        if (bit_cnt_q == '0) begin
          state_d = STOP;
        end else begin
          bit_cnt_d = bit_cnt_q - BW'(1);
        end
      end

      STOP: begin
        word_out_d   = shift_q;
        word_write_d = 1'b1;
        word_cnt_d   = words_inc;
        if (bit_b) begin
          frame_complete_d = 1'b1;
          frame_words_d    = words_inc;
          state_d          = IDLE;
        end else if (words_inc == CW'(MAX_WORDS)) begin
          frame_error_d = 1'b1;
          frame_words_d = CW'(MAX_WORDS);
          idle_cnt_d    = '0;
          state_d       = FLUSH;
        end else begin
          // No start bit between words: go straight to the next data bits.
          bit_cnt_d = BW'(WORD_WIDTH - 1);
          state_d   = RECEIVE;
        end
      end

      FLUSH: begin
        if (bit_b) begin
          if (idle_inc == FW'(IDLE_BITS)) begin
            state_d = IDLE;
          end else begin
            idle_cnt_d = idle_inc;
          end
        end else begin
          idle_cnt_d = '0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      s_d1_q           <= '1;
      s_d2_q           <= '1;
      state_q          <= IDLE;
      bit_cnt_q        <= '0;
      word_cnt_q       <= '0;
      idle_cnt_q       <= '0;
      shift_q          <= '0;
      word_out_q       <= '0;
      word_write_q     <= 1'b0;
      frame_complete_q <= 1'b0;
      frame_error_q    <= 1'b0;
      frame_words_q    <= '0;
    end else begin
      s_d1_q           <= samples;
      s_d2_q           <= s_d1_q;
      state_q          <= state_d;
      bit_cnt_q        <= bit_cnt_d;
      word_cnt_q       <= word_cnt_d;
      idle_cnt_q       <= idle_cnt_d;
      shift_q          <= shift_d;
      word_out_q       <= word_out_d;
      word_write_q     <= word_write_d;
      frame_complete_q <= frame_complete_d;
      frame_error_q    <= frame_error_d;
      frame_words_q    <= frame_words_d;
    end
  end

  assign word_out       = word_out_q;
  assign word_write     = word_write_q;
  assign frame_complete = frame_complete_q;
  assign frame_error    = frame_error_q;
  assign frame_words    = frame_words_q;

endmodule

// File: tb/tb_oversampling_rx_framer.sv
// tb_oversampling_rx_framer
// Directed bench: serialises frames into an OSR-sample stream, drives both a
// default instance and a MAX_WORDS=2 instance, logs every word_write and
// compares against hand-computed words, cycles and frame flags.
module tb_oversampling_rx_framer;

  localparam int OSR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           sync_reset;
  logic           enable;
  logic [OSR-1:0] samples;

  logic [7:0] word_out1, word_out2;
  logic       ww1, ww2, fc1, fc2, fe1, fe2;
  logic [4:0] fw1;
  logic [1:0] fw2;

  oversampling_rx_framer dut (
    .clk            (clk),
    .sync_reset     (sync_reset),
    .enable         (enable),
    .samples        (samples),
    .word_out       (word_out1),
    .word_write     (ww1),
    .frame_complete (fc1),
    .frame_words    (fw1),
    .frame_error    (fe1)
  );

  oversampling_rx_framer #(.MAX_WORDS(2)) dut_mw2 (
    .clk            (clk),
    .sync_reset     (sync_reset),
    .enable         (enable),
    .samples        (samples),
    .word_out       (word_out2),
    .word_write     (ww2),
    .frame_complete (fc2),
    .frame_words    (fw2),
    .frame_error    (fe2)
  );

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       fc;
    logic       fe;
    int         fw;
  } wr_t;

  wr_t  log1[$];
  wr_t  log2[$];
  logic sq[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   viol1  = 0;
  int   viol2  = 0;
  int   e;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    logic [OSR-1:0] v;
    for (int k = 0; k < OSR; k++) begin
      v[k] = (sq.size() > 0) ? sq.pop_front() : 1'b1;
    end
    samples = v;
    @(posedge clk);
    #1;
    cyc++;
    if (ww1) log1.push_back('{cyc, word_out1, fc1, fe1, int'(fw1)});
    if (ww2) log2.push_back('{cyc, word_out2, fc2, fe2, int'(fw2)});
    if (((fc1 || fe1) && !ww1) || (fc1 && fe1)) viol1++;
    if (((fc2 || fe2) && !ww2) || (fc2 && fe2)) viol2++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic push_bit(input logic b);
    repeat (OSR) sq.push_back(b);
  endtask

  task automatic push_start(input int off);
    repeat (off) sq.push_back(1'b1);
    push_bit(1'b0);
  endtask

  task automatic push_word(input logic [7:0] w, input logic cont);
    for (int k = 0; k < 8; k++) push_bit(w[k]);
    push_bit(cont);
  endtask

  task automatic clear_logs();
    log1.delete();
    log2.delete();
  endtask

  task automatic expect_wr(input string tag, input int which, input int idx, input int ecyc,
                           input logic [7:0] edata, input logic efc, input logic efe,
                           input int efw);
    wr_t w;
    int  n;
    n = (which == 1) ? log1.size() : log2.size();
    check({tag, "_present"}, 32'(idx < n), 1);
    if (idx < n) begin
      if (which == 1) w = log1[idx];
      else            w = log2[idx];
      check({tag, "_cyc"},  w.cyc,  ecyc);
      check({tag, "_data"}, w.data, edata);
      check({tag, "_fc"},   w.fc,   efc);
      check({tag, "_fe"},   w.fe,   efe);
      if (efc || efe) check({tag, "_fw"}, w.fw, efw);
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_word_out"}, word_out1, 0);
    check({tag, "_ww"},       ww1, 0);
    check({tag, "_fc"},       fc1, 0);
    check({tag, "_fe"},       fe1, 0);
    check({tag, "_fw"},       fw1, 0);
    check({tag, "_word_out2"}, word_out2, 0);
  endtask

  initial begin
    sync_reset = 1'b1;
    enable     = 1'b0;
    samples    = '1;

    // Reset state
    run(3);
    check_cleared("rst");
    check("rst_p", dut.p_q, 0);
    sync_reset = 1'b0;
    enable     = 1'b1;
    run(3);

    // 1-word frame 0xA5, edge at samples[2]
    clear_logs();
    e = cyc;
    push_start(2);
    push_word(8'hA5, 1'b1);
    run(20);
    check("a_count", log1.size(), 1);
    expect_wr("a_w0", 1, 0, e + 12, 8'hA5, 1'b1, 1'b0, 1);
    check("a_p", dut.p_q, 4);

    // 3-word frame, edge at samples[0] then samples[3]
    for (int r = 0; r < 2; r++) begin
      clear_logs();
      e = cyc;
      push_start((r == 0) ? 0 : 3);
      push_word(8'h01, 1'b0);
      push_word(8'hFF, 1'b0);
      push_word(8'h80, 1'b1);
      run(40);
      check($sformatf("b%0d_count", r), log1.size(), 3);
      expect_wr($sformatf("b%0d_w0", r), 1, 0, e + 12, 8'h01, 1'b0, 1'b0, 0);
      expect_wr($sformatf("b%0d_w1", r), 1, 1, e + 21, 8'hFF, 1'b0, 1'b0, 0);
      expect_wr($sformatf("b%0d_w2", r), 1, 2, e + 30, 8'h80, 1'b1, 1'b0, 3);
    end
    check("b1_p", dut.p_q, 5);

    // 1-sample glitch in samples[3] is a false start
    clear_logs();
    sq.push_back(1'b1); sq.push_back(1'b1); sq.push_back(1'b1); sq.push_back(1'b0);
    run(15);
    check("glitch_count", log1.size(), 0);

    // enable low: frame ignored
    clear_logs();
    enable = 1'b0;
    push_start(1);
    push_word(8'hA5, 1'b1);
    run(20);
    check("en_low_count", log1.size(), 0);

    // enable dropped mid-frame: frame still completes
    clear_logs();
    enable = 1'b1;
    e = cyc;
    push_start(1);
    push_word(8'hC3, 1'b1);
    run(4);
    enable = 1'b0;
    run(16);
    enable = 1'b1;
    check("en_mid_count", log1.size(), 1);
    expect_wr("en_mid_w0", 1, 0, e + 12, 8'hC3, 1'b1, 1'b0, 1);

    // MAX_WORDS=2 overflow, flush, then a clean frame
    sync_reset = 1'b1;
    run(2);
    sync_reset = 1'b0;
    clear_logs();
    e = cyc;
    push_start(0);
    push_word(8'h11, 1'b0);
    push_word(8'h22, 1'b0);
    push_word(8'h70, 1'b0);  // only three consecutive 1 bits: must not end FLUSH
    run(40);
    check("mw_count", log2.size(), 2);
    expect_wr("mw_w0", 2, 0, e + 12, 8'h11, 1'b0, 1'b0, 0);
    expect_wr("mw_w1", 2, 1, e + 21, 8'h22, 1'b0, 1'b1, 2);
    clear_logs();
    e = cyc;
    push_start(1);
    push_word(8'h3C, 1'b1);
    run(20);
    check("mw_new_count", log2.size(), 1);
    expect_wr("mw_new_w0", 2, 0, e + 12, 8'h3C, 1'b1, 1'b0, 1);
    expect_wr("mw_new_d1", 1, 0, e + 12, 8'h3C, 1'b1, 1'b0, 1);

    // Reset mid-word aborts silently
    clear_logs();
    push_start(0);
    push_word(8'h77, 1'b1);
    run(6);
    sync_reset = 1'b1;
    sq.delete();
    run(1);
    sync_reset = 1'b0;
    check_cleared("mid_rst");
    run(15);
    check("mid_rst_count", log1.size(), 0);
    e = cyc;
    push_start(3);
    push_word(8'h5A, 1'b1);
    run(20);
    check("mid_rst_new_count", log1.size(), 1);
    expect_wr("mid_rst_w0", 1, 0, e + 12, 8'h5A, 1'b1, 1'b0, 1);

    // Flipped sample at h[p] in data bit 3 of 0x00 (offset 0, p=2)
    clear_logs();
    e = cyc;
    push_start(0);
    push_word(8'h00, 1'b1);
    sq[(1 + 3) * OSR + 2] = 1'b1;
    run(20);
`ifdef OVERSAMPLING_RX_MAJORITY_EN
    expect_wr("maj_w0", 1, 0, e + 12, 8'h00, 1'b1, 1'b0, 1);
`else
    expect_wr("maj_w0", 1, 0, e + 12, 8'h08, 1'b1, 1'b0, 1);
`endif

    check("strobe_consist", viol1, 0);
    check("strobe_consist_mw2", viol2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
